// File: rtl/fifo_uart_tx.sv
`default_nettype none
// =====================================================================
// Module : fifo_uart_tx
// Pops bytes from a synchronous fifo and sends each as an 8N1 UART frame.
// Rev    : 1.0  initial release
// =====================================================================
module fifo_uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [DATA_BITS-1:0] fifo_dout_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_en_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_READ  = 3'd1;
  localparam logic [2:0] c_S_LOAD  = 3'd2;
  localparam logic [2:0] c_S_START = 3'd3;
  localparam logic [2:0] c_S_DATA  = 3'd4;
  localparam logic [2:0] c_S_STOP  = 3'd5;

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic [c_BAUD_W-1:0]  r_baud;
  logic [c_IDX_W-1:0]   r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_baud_last;
  logic                 w_bit_phase;

  assign w_baud_last = (r_baud == c_BAUD_LAST);
  assign w_bit_phase = (r_state == c_S_START) || (r_state == c_S_DATA) ||
                       (r_state == c_S_STOP);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_S_IDLE:  if (enable_i && !fifo_empty_i) w_state_next = c_S_READ;
      c_S_READ:  w_state_next = c_S_LOAD;
      c_S_LOAD:  w_state_next = c_S_START;
      c_S_START: if (w_baud_last) w_state_next = c_S_DATA;
      c_S_DATA:  if (w_baud_last && (r_bit_idx == c_IDX_LAST)) w_state_next = c_S_STOP;
      c_S_STOP:  if (w_baud_last) w_state_next = c_S_IDLE;
      default:   w_state_next = c_S_IDLE;
    endcase
  end

  // Baud counter restarts on every state change and on every bit boundary.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if ((w_state_next != r_state) || w_baud_last) begin
        r_baud <= '0;
      end else if (w_bit_phase) begin
        r_baud <= r_baud + 1'b1;
      end

      if (r_state == c_S_LOAD) begin
        r_shift <= fifo_dout_i;
      end else if ((r_state == c_S_DATA) && w_baud_last) begin
        r_shift <= r_shift >> 1;
      end

      if (r_state == c_S_START) begin
        r_bit_idx <= '0;
      end else if ((r_state == c_S_DATA) && w_baud_last) begin
        r_bit_idx <= (r_bit_idx == c_IDX_LAST) ? '0 : r_bit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    tx_o         = 1'b1;
    fifo_rd_en_o = 1'b0;
    frame_done_o = 1'b0;
    busy_o       = (r_state != c_S_IDLE);
    case (r_state)
      c_S_READ:  fifo_rd_en_o = 1'b1;
      c_S_START: tx_o = 1'b0;
      c_S_DATA:  tx_o = r_shift[0];
      c_S_STOP:  frame_done_o = w_baud_last;
      default:   tx_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// Bench for fifo_uart_tx: bench-side fifo, frame-timeline reference model,
// per-cycle output compare plus literal frame expectations.
module tb_fifo_uart_tx;

  localparam int DB   = 8;
  localparam int CLKS = 4;
  localparam int FLEN = 2 + (DB + 2) * CLKS;

  logic          clk_tb     = 1'b0;
  logic          rst        = 1'b1;
  logic          enable     = 1'b0;
  logic [DB-1:0] fifo_dout  = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic          tx;
  logic          busy;
  logic          frame_done;
  logic          push_valid = 1'b0;
  logic [DB-1:0] push_data  = '0;

  fifo_uart_tx #(
    .DATA_BITS   (DB),
    .CLKS_PER_BIT(CLKS)
  ) dut (
    .clk_i       (clk_tb),
    .reset_i     (rst),
    .enable_i    (enable),
    .fifo_dout_i (fifo_dout),
    .fifo_empty_i(fifo_empty),
    .fifo_rd_en_o(fifo_rd_en),
    .tx_o        (tx),
    .busy_o      (busy),
    .frame_done_o(frame_done)
  );

  always #5 clk_tb = ~clk_tb;

  // Synchronous fifo: read data appears the cycle after rd_en is sampled.
  logic [DB-1:0] fq[$];
  always @(posedge clk_tb) begin
    if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
    if (push_valid) fq.push_back(push_data);
    fifo_empty <= (fq.size() == 0);
  end

  // Reference model: mk = cycles since the start-decision edge, -1 when idle.
  int            mk   = -1;
  logic [DB-1:0] mcur = '0;
  logic [DB-1:0] mq[$];
  always @(posedge clk_tb) begin
    if (rst) begin
      mk = -1;
    end else if (mk >= 0) begin
      mk = (mk + 1 == FLEN) ? -1 : mk + 1;
    end else if (enable && !fifo_empty) begin
      mk = 0;
      if (mq.size() > 0) mcur = mq.pop_front();
    end
    if (push_valid) mq.push_back(push_data);
  end

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   busy_cycles = 0;
  logic txlog[$];
  int   rdlog[$];
  int   donelog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): actual 0x%0h, required 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic [3:0] exp_o;
    int p;
    int b;
    @(negedge clk_tb);
    exp_o = 4'b1000;  // {tx, rd_en, busy, frame_done}
    if (mk == 0) begin
      exp_o = 4'b1110;
    end else if (mk == 1) begin
      exp_o = 4'b1010;
    end else if (mk >= 2) begin
      p = mk - 2;
      b = p / CLKS;
      if (b == 0)       exp_o[3] = 1'b0;
      else if (b <= DB) exp_o[3] = mcur[b-1];
      else              exp_o[3] = 1'b1;
      exp_o[2] = 1'b0;
      exp_o[1] = 1'b1;
      exp_o[0] = (p == (DB + 2) * CLKS - 1);
    end
    chk("outputs{tx,rd,busy,done}", {28'b0, tx, fifo_rd_en, busy, frame_done}, {28'b0, exp_o});
    txlog.push_back(tx);
    if (fifo_rd_en) rdlog.push_back(cyc);
    if (frame_done) donelog.push_back(cyc);
    if (busy) busy_cycles++;
    cyc++;
  endtask

  task automatic push(input logic [DB-1:0] d);
    push_valid = 1'b1;
    push_data  = d;
    step();
    push_valid = 1'b0;
  endtask

  task automatic run_until_idle(input string name);
    int i = 0;
    repeat (4) step();
    while ((busy || (!fifo_empty && enable)) && i < 20000) begin
      step();
      i++;
    end
    chk(name, {31'b0, busy}, 32'd0);
  endtask

  // Samples each bit of a frame starting at log index s, LSB = start bit.
  function automatic logic [DB+1:0] frame_at(input int s);
    logic [DB+1:0] f;
    for (int b = 0; b < DB + 2; b++) begin
      if (s + b * CLKS + 1 < txlog.size()) f[b] = txlog[s + b * CLKS + 1];
      else f[b] = 1'bx;
    end
    return f;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int r;
    int base;
    int dbase;

    rst = 1'b1;
    enable = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (50) step();
    chk("idle_rd_pulses", rdlog.size(), 0);
    chk("idle_busy_cycles", busy_cycles, 0);
    chk("idle_tx", {31'b0, tx}, 1);

    push(8'hF0);
    run_until_idle("f0_idle");
    chk("f0_rd_pulses", rdlog.size(), 1);
    chk("f0_done_pulses", donelog.size(), 1);
    if (rdlog.size() >= 1 && donelog.size() >= 1) begin
      chk("f0_frame", {22'b0, frame_at(rdlog[0] + 2)}, 32'h3E0);
      chk("f0_done_cycle", donelog[0] - (rdlog[0] + 2), 39);
    end

    base  = rdlog.size();
    dbase = donelog.size();
    push(8'h55);
    push(8'hA3);
    run_until_idle("pair_idle");
    chk("pair_rd_pulses", rdlog.size() - base, 2);
    chk("pair_done_pulses", donelog.size() - dbase, 2);
    if (rdlog.size() >= base + 2) begin
      chk("pair_frame0", {22'b0, frame_at(rdlog[base] + 2)}, 32'h2AA);
      chk("pair_frame1", {22'b0, frame_at(rdlog[base+1] + 2)}, 32'h346);
      chk("pair_gap", (rdlog[base+1] + 2) - (rdlog[base] + 2 + 40), 3);
    end

    base = rdlog.size();
    for (int i = 0; i < 8; i++) push(8'(i));
    run_until_idle("burst_idle");
    chk("burst_rd_pulses", rdlog.size() - base, 8);
    chk("burst_empty", {31'b0, fifo_empty}, 1);
    for (int i = 0; i < 8; i++) begin
      if (base + i < rdlog.size())
        chk($sformatf("burst_frame%0d", i), {22'b0, frame_at(rdlog[base+i] + 2)},
            {22'b0, 1'b1, 8'(i), 1'b0});
    end

    base = rdlog.size();
    push(8'h3C);
    push(8'h99);
    n = 0;
    while (rdlog.size() == base && n < 50) begin
      step();
      n++;
    end
    chk("drop_first_rd", rdlog.size() - base, 1);
    repeat (20) step();
    enable = 1'b0;
    run_until_idle("drop_idle");
    repeat (20) step();
    chk("drop_rd_while_disabled", rdlog.size() - base, 1);
    chk("drop_still_queued", {31'b0, fifo_empty}, 0);
    if (rdlog.size() > base) chk("drop_frame", {22'b0, frame_at(rdlog[base] + 2)}, 32'h278);
    n = cyc;
    enable = 1'b1;
    repeat (3) step();
    chk("resume_rd_cycle", (rdlog.size() > base + 1) ? rdlog[base+1] - n : -1, 0);
    chk("resume_tx_fall", {30'b0, txlog[n+1], txlog[n+2]}, 32'b10);
    run_until_idle("resume_idle");
    if (rdlog.size() > base + 1)
      chk("resume_frame", {22'b0, frame_at(rdlog[base+1] + 2)}, {22'b0, 1'b1, 8'h99, 1'b0});

    base = rdlog.size();
    push(8'h00);
    push(8'hC5);
    n = 0;
    while (rdlog.size() == base && n < 50) begin
      step();
      n++;
    end
    r = (rdlog.size() > base) ? rdlog[base] : cyc;
    while (cyc <= r + 19) step();
    #1;
    chk("pre_reset_tx_bit3", {31'b0, tx}, 0);
    chk("pre_reset_busy", {31'b0, busy}, 1);
    rst = 1'b1;
    #1;
    chk("async_reset_tx", {31'b0, tx}, 1);
    chk("async_reset_busy", {31'b0, busy}, 0);
    chk("async_reset_rd", {31'b0, fifo_rd_en}, 0);
    chk("async_reset_done", {31'b0, frame_done}, 0);
    repeat (3) step();
    rst = 1'b0;
    run_until_idle("post_reset_idle");
    chk("post_reset_rd_pulses", rdlog.size() - base, 2);
    if (rdlog.size() > base + 1)
      chk("post_reset_frame", {22'b0, frame_at(rdlog[base+1] + 2)}, 32'h38A);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 31) == 0) enable = ~enable;
      if ($urandom_range(0, 47) == 0) push(8'($urandom));
      else step();
    end
    enable = 1'b1;
    run_until_idle("random_drain");
    chk("random_empty", {31'b0, fifo_empty}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
